// File: rtl/window3x3_gen.sv
// Raster-to-3x3 window generator: two line buffers plus a 3x3 shift window.
// Emits one registered window per accepted pixel once the window lies fully inside the frame.
module window3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout00,
    output logic [DATA_WIDTH-1:0] dout01,
    output logic [DATA_WIDTH-1:0] dout02,
    output logic [DATA_WIDTH-1:0] dout10,
    output logic [DATA_WIDTH-1:0] dout11,
    output logic [DATA_WIDTH-1:0] dout12,
    output logic [DATA_WIDTH-1:0] dout20,
    output logic [DATA_WIDTH-1:0] dout21,
    output logic [DATA_WIDTH-1:0] dout22,
    output logic                  dout_valid,
    output logic                  dout_eof
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t                             state_q, state_d;
    logic [CW-1:0]                      col_q, col_d;
    logic [RW-1:0]                      row_q, row_d;
    logic [2:0][2:0][DATA_WIDTH-1:0]    win_q, win_d;
    logic                               valid_q, valid_d;
    logic                               eof_q, eof_d;
    logic [DATA_WIDTH-1:0]              lb0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]              lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]              rd0_s, rd1_s;
    logic                               last_col_s, last_row_s;

    // lb0 holds row r-1, lb1 holds row r-2, both indexed by the current column
    assign rd0_s      = lb0_q[col_q];
    assign rd1_s      = lb1_q[col_q];
    assign last_col_s = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row_s = (row_q == RW'(IMG_HEIGHT - 1));

    // Next-state for counters, FSM, window shift and output strobes
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        win_d   = win_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        if (din_valid) begin
            win_d[0] = {rd1_s,    win_q[0][2], win_q[0][1]};
            win_d[1] = {rd0_s,    win_q[1][2], win_q[1][1]};
            win_d[2] = {din_data, win_q[2][2], win_q[2][1]};
            // Columns 0 and 1 straddle two lines in the shift registers
            valid_d  = (state_q == RUN) && (col_q >= CW'(2));
            eof_d    = valid_d && last_col_s && last_row_s;
            if (last_col_s) begin
                col_d = '0;
                if (last_row_s) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
            case (state_q)
                FILL: begin
                    if (last_col_s && (row_q == RW'(1))) begin
                        state_d = RUN;
                    end else begin
                        state_d = FILL;
                    end
                end
                RUN: begin
                    if (last_col_s && last_row_s) begin
                        state_d = FILL;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = FILL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and window registers with asynchronous reset
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
        end
    end

    // Line-buffer RAM: read-before-write at the same address, no reset
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= din_data;
        end
    end

    assign dout00     = win_q[0][0];
    assign dout01     = win_q[0][1];
    assign dout02     = win_q[0][2];
    assign dout10     = win_q[1][0];
    assign dout11     = win_q[1][1];
    assign dout12     = win_q[1][2];
    assign dout20     = win_q[2][0];
    assign dout21     = win_q[2][1];
    assign dout22     = win_q[2][2];
    assign dout_valid = valid_q;
    assign dout_eof   = eof_q;
endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: a 4x4 instance and a 5x3 instance on one clock.
module tb_window3x3_gen;
    typedef logic [8:0][7:0] win_t;   // index R*3+C

    logic clk;
    logic arst;
    logic [7:0] a_din, b_din;
    logic a_vld, b_vld;
    logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
    logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
    logic a_vo, a_eof, b_vo, b_eof;
    win_t a_win, b_win;

    int checks = 0;
    int errors = 0;

    win_t qa[$];
    bit   qa_eof[$];
    win_t qb[$];
    bit   qb_eof[$];
    int   dbl_a = 0;
    bit   a_prev = 1'b0;

    window3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
        .clk(clk), .arst(arst), .din_data(a_din), .din_valid(a_vld),
        .dout00(a00), .dout01(a01), .dout02(a02),
        .dout10(a10), .dout11(a11), .dout12(a12),
        .dout20(a20), .dout21(a21), .dout22(a22),
        .dout_valid(a_vo), .dout_eof(a_eof));

    window3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_b (
        .clk(clk), .arst(arst), .din_data(b_din), .din_valid(b_vld),
        .dout00(b00), .dout01(b01), .dout02(b02),
        .dout10(b10), .dout11(b11), .dout12(b12),
        .dout20(b20), .dout21(b21), .dout22(b22),
        .dout_valid(b_vo), .dout_eof(b_eof));

    assign a_win = {a22, a21, a20, a12, a11, a10, a02, a01, a00};
    assign b_win = {b22, b21, b20, b12, b11, b10, b02, b01, b00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every emitted window between clock edges
    always @(negedge clk) begin
        if (a_vo) begin
            qa.push_back(a_win);
            qa_eof.push_back(a_eof);
        end
        if (a_vo && a_prev) dbl_a++;
        a_prev = a_vo;
        if (b_vo) begin
            qb.push_back(b_win);
            qb_eof.push_back(b_eof);
        end
    end

    // Reference window ending at (r,c) for pixel = base + row*16 + col
    function automatic win_t exp_win(input int base, input int r, input int c);
        win_t w;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[rr*3+cc] = 8'(base + (r - 2 + rr) * 16 + (c - 2 + cc));
        return w;
    endfunction

    task automatic do_reset();
        a_vld = 1'b0;
        b_vld = 1'b0;
        arst  = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;
        qa.delete(); qa_eof.delete();
        qb.delete(); qb_eof.delete();
        dbl_a = 0;
    endtask

    task automatic feed_a(input int base, input int npix);
        for (int p = 0; p < npix; p++) begin
            a_din = 8'(base + (p / 4) * 16 + (p % 4));
            a_vld = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        a_vld = 1'b0;
        b_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        #1;
        checks++;
        if (a_win !== '0 || a_vo !== 1'b0 || a_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got win=%h v=%b e=%b, want all zero", a_win, a_vo, a_eof);
        end
        checks++;
        if (b_win !== '0 || b_vo !== 1'b0 || b_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got win=%h v=%b e=%b, want all zero", b_win, b_vo, b_eof);
        end
        do_reset();
    endtask

    task automatic test_continuous();
        win_t first_e;
        do_reset();
        feed_a(0, 16);
        drain();
        checks++;
        if (qa.size() != 4) begin
            errors++;
            $display("FAIL cont_count: got %0d windows, want 4", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            checks++;
            if (qa[i] !== exp_win(0, 2 + i / 2, 2 + i % 2) || qa_eof[i] !== (i == 3)) begin
                errors++;
                $display("FAIL cont_win%0d: got %h eof=%b, want %h eof=%b",
                         i, qa[i], qa_eof[i], exp_win(0, 2 + i / 2, 2 + i % 2), i == 3);
            end
        end
        first_e = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
        if (qa.size() == 4) begin
            checks++;
            if (qa[0] !== first_e) begin
                errors++;
                $display("FAIL cont_first: got %h, want %h", qa[0], first_e);
            end
            checks++;
            if (qa[3][0] !== 8'h11 || qa[3][8] !== 8'h33 || qa_eof[3] !== 1'b1) begin
                errors++;
                $display("FAIL cont_last: got d00=%h d22=%h eof=%b, want 11 33 1",
                         qa[3][0], qa[3][8], qa_eof[3]);
            end
        end
    endtask

    task automatic test_gaps();
        win_t snap;
        int gap;
        do_reset();
        for (int p = 0; p < 16; p++) begin
            a_din = 8'((p / 4) * 16 + (p % 4));
            a_vld = 1'b1;
            @(posedge clk);
            #1;
            a_vld = 1'b0;
            snap  = a_win;
            gap   = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                checks++;
                if (a_win !== snap || a_vo !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold p%0d: got %h v=%b, want %h v=0", p, a_win, a_vo, snap);
                end
            end
        end
        drain();
        checks++;
        if (qa.size() != 4) begin
            errors++;
            $display("FAIL gap_count: got %0d windows, want 4", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            checks++;
            if (qa[i] !== exp_win(0, 2 + i / 2, 2 + i % 2) || qa_eof[i] !== (i == 3)) begin
                errors++;
                $display("FAIL gap_win%0d: got %h eof=%b, want %h", i, qa[i], qa_eof[i],
                         exp_win(0, 2 + i / 2, 2 + i % 2));
            end
        end
        checks++;
        if (dbl_a != 0) begin
            errors++;
            $display("FAIL gap_pulse: got %0d consecutive valid cycles, want 0", dbl_a);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit mixed;
        do_reset();
        feed_a(0, 16);
        feed_a(8'h80, 16);
        drain();
        checks++;
        if (qa.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d windows, want 8", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 8; i++) begin
            base = (i < 4) ? 0 : 8'h80;
            checks++;
            if (qa[i] !== exp_win(base, 2 + (i % 4) / 2, 2 + i % 2) || qa_eof[i] !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL b2b_win%0d: got %h eof=%b, want %h", i, qa[i], qa_eof[i],
                         exp_win(base, 2 + (i % 4) / 2, 2 + i % 2));
            end
            mixed = 1'b0;
            for (int k = 1; k < 9; k++)
                if (qa[i][k][7] !== qa[i][0][7]) mixed = 1'b1;
            checks++;
            if (mixed) begin
                errors++;
                $display("FAIL b2b_mix%0d: got %h, want single-frame data", i, qa[i]);
            end
        end
        if (qa.size() >= 5) begin
            checks++;
            if (qa[4][0] !== 8'h80 || qa[4][8] !== 8'hA2) begin
                errors++;
                $display("FAIL b2b_f2first: got d00=%h d22=%h, want 80 A2", qa[4][0], qa[4][8]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        feed_a(0, 10);
        a_vld = 1'b0;
        arst  = 1'b1;
        #1;
        checks++;
        if (a_win !== '0 || a_vo !== 1'b0 || a_eof !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got win=%h v=%b, want zero", a_win, a_vo);
        end
        @(posedge clk);
        #1;
        arst = 1'b0;
        qa.delete(); qa_eof.delete();
        feed_a(0, 16);
        drain();
        checks++;
        if (qa.size() != 4) begin
            errors++;
            $display("FAIL mid_count: got %0d windows, want 4", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            checks++;
            if (qa[i] !== exp_win(0, 2 + i / 2, 2 + i % 2) || qa_eof[i] !== (i == 3)) begin
                errors++;
                $display("FAIL mid_win%0d: got %h, want %h", i, qa[i], exp_win(0, 2 + i / 2, 2 + i % 2));
            end
        end
    endtask

    task automatic test_w5h3();
        logic [7:0] want22 [3];
        want22[0] = 8'h22; want22[1] = 8'h23; want22[2] = 8'h24;
        do_reset();
        for (int p = 0; p < 15; p++) begin
            b_din = 8'((p / 5) * 16 + (p % 5));
            b_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        drain();
        checks++;
        if (qb.size() != 3) begin
            errors++;
            $display("FAIL w5h3_count: got %0d windows, want 3", qb.size());
        end
        for (int i = 0; i < qb.size() && i < 3; i++) begin
            checks++;
            if (qb[i][8] !== want22[i] || qb_eof[i] !== (i == 2) || qb[i] !== exp_win(0, 2, 2 + i)) begin
                errors++;
                $display("FAIL w5h3_win%0d: got %h eof=%b, want d22=%h eof=%b",
                         i, qb[i], qb_eof[i], want22[i], i == 2);
            end
        end
    endtask

    task automatic test_median();
        int v [9];
        int t;
        int ref_med;
        do_reset();
        feed_a(0, 16);
        drain();
        checks++;
        if (qa.size() != 4) begin
            errors++;
            $display("FAIL med_count: got %0d windows, want 4", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 4; i++) begin
            for (int k = 0; k < 9; k++) v[k] = int'(qa[i][k]);
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8 - x; y++)
                    if (v[y] > v[y+1]) begin t = v[y]; v[y] = v[y+1]; v[y+1] = t; end
            // Grid values are monotone in row and column, so the median is the centre pixel
            ref_med = (1 + i / 2) * 16 + (1 + i % 2);
            checks++;
            if (v[4] != ref_med) begin
                errors++;
                $display("FAIL med_win%0d: got %h, want %h", i, v[4], ref_med);
            end
        end
    endtask

    initial begin
        arst  = 1'b1;
        a_din = 8'h00;
        b_din = 8'h00;
        a_vld = 1'b0;
        b_vld = 1'b0;
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_w5h3();
        test_median();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
